// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================
// Package : fft_pkg
// Shared width helpers, sample type and twiddle unity constant.
// Rev     : 1.0
// ============================================================
package fft_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int TW_FRAC_DEF = 14;
    localparam int TW_ONE      = 1 << TW_FRAC_DEF;

    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] re;
        logic signed [DATA_W_DEF-1:0] im;
    } cplx_t;

    function automatic int pw(input int data_w, input int tw_w);
        return data_w + tw_w + 2;
    endfunction

    function automatic int base_drop(input int tw_frac, input int out_frac);
        return tw_frac - out_frac;
    endfunction

endpackage
`default_nettype wire

// File: rtl/butterfly_unit_pipelined_round_sat.sv
`default_nettype none
// ============================================================
// Module : round_sat
// Round half toward +inf over BASE_DROP (+1 when scaling), then clamp.
// Rev    : 1.0
// ============================================================
module round_sat #(
    parameter int IN_W      = 35,
    parameter int OUT_W     = 24,
    parameter int BASE_DROP = 9
) (
    input  logic signed [IN_W-1:0]  din,
    input  logic                    scale,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);

    // One guard bit so the rounding increment can never wrap.
    localparam logic signed [IN_W:0] c_half1 = (IN_W+1)'(1) << BASE_DROP;

    logic signed [IN_W:0] w_ext;
    logic signed [IN_W:0] w_r0;
    logic signed [IN_W:0] w_r1;
    logic signed [IN_W:0] w_rnd;

    assign w_ext = {din[IN_W-1], din};
    assign w_r1  = (w_ext + c_half1) >>> (BASE_DROP + 1);

    generate
        if (BASE_DROP == 0) begin : g_nodrop
            assign w_r0 = w_ext;
        end else begin : g_drop
            localparam logic signed [IN_W:0] c_half0 = (IN_W+1)'(1) << (BASE_DROP - 1);
            assign w_r0 = (w_ext + c_half0) >>> BASE_DROP;
        end
    endgenerate

    assign w_rnd = scale ? w_r1 : w_r0;

    generate
        if (OUT_W <= IN_W) begin : g_clamp
            localparam logic signed [IN_W:0] c_max = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [IN_W:0] c_min = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
            always_comb begin
                sat  = 1'b0;
                dout = w_rnd[OUT_W-1:0];
                if (w_rnd > c_max) begin
                    sat  = 1'b1;
                    dout = c_max[OUT_W-1:0];
                end else if (w_rnd < c_min) begin
                    sat  = 1'b1;
                    dout = c_min[OUT_W-1:0];
                end
            end
        end else begin : g_wide
            assign sat  = 1'b0;
            assign dout = OUT_W'(w_rnd);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/butterfly_unit_pipelined.sv
`default_nettype none
// ============================================================
// Module : butterfly_unit_pipelined
// Three-stage radix-2 DIT butterfly with valid/ready and saturation.
// Rev    : 1.0
// ============================================================
module butterfly_unit_pipelined
    import fft_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int TW_W     = 16,
    parameter int TW_FRAC  = 14,
    parameter int OUT_W    = 24,
    parameter int OUT_FRAC = 5,
    parameter int TAG_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in1_re,
    input  logic signed [DATA_W-1:0] in1_im,
    input  logic signed [DATA_W-1:0] in2_re,
    input  logic signed [DATA_W-1:0] in2_im,
    input  logic signed [TW_W-1:0]   tw_re,
    input  logic signed [TW_W-1:0]   tw_im,
    input  logic                     in_inverse,
    input  logic                     in_scale,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out1_re,
    output logic signed [OUT_W-1:0]  out1_im,
    output logic signed [OUT_W-1:0]  out2_re,
    output logic signed [OUT_W-1:0]  out2_im,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     ovf_sticky,
    input  logic                     clr_ovf
);

    localparam int c_pw = pw(DATA_W, TW_W);
    localparam int c_mw = DATA_W + TW_W + 1;

    logic w_adv;
    assign in_ready = !(out_valid && !out_ready);
    assign w_adv    = in_ready;

    // Operands widened so that each product is full precision and -(-2^(TW_W-1)) is exact.
    logic signed [c_mw-1:0] w_b_re, w_b_im, w_w_re, w_w_im;
    assign w_b_re = c_mw'(in2_re);
    assign w_b_im = c_mw'(in2_im);
    assign w_w_re = c_mw'(tw_re);
    assign w_w_im = in_inverse ? -c_mw'(tw_im) : c_mw'(tw_im);

    logic                     r_s1_valid, r_s2_valid;
    logic signed [c_mw-1:0]   r_s1_rr, r_s1_ii, r_s1_ri, r_s1_ir;
    logic signed [DATA_W-1:0] r_s1_in1_re, r_s1_in1_im;
    logic                     r_s1_scale, r_s2_scale;
    logic [TAG_W-1:0]         r_s1_tag, r_s2_tag;
    logic signed [c_pw-1:0]   r_s2_pre, r_s2_pim, r_s2_a_re, r_s2_a_im;

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s1_rr     <= w_b_re * w_w_re;
            r_s1_ii     <= w_b_im * w_w_im;
            r_s1_ri     <= w_b_re * w_w_im;
            r_s1_ir     <= w_b_im * w_w_re;
            r_s1_in1_re <= in1_re;
            r_s1_in1_im <= in1_im;
            r_s1_scale  <= in_scale;
            r_s1_tag    <= in_tag;
            r_s2_pre    <= c_pw'(r_s1_rr) - c_pw'(r_s1_ii);
            r_s2_pim    <= c_pw'(r_s1_ri) + c_pw'(r_s1_ir);
            r_s2_a_re   <= c_pw'(r_s1_in1_re) <<< TW_FRAC;
            r_s2_a_im   <= c_pw'(r_s1_in1_im) <<< TW_FRAC;
            r_s2_scale  <= r_s1_scale;
            r_s2_tag    <= r_s1_tag;
        end
    end

    logic signed [c_pw:0]    w_sum [4];
    logic signed [OUT_W-1:0] w_rs  [4];
    logic [3:0]              w_sat;

    assign w_sum[0] = (c_pw+1)'(r_s2_a_re) + (c_pw+1)'(r_s2_pre);
    assign w_sum[1] = (c_pw+1)'(r_s2_a_im) + (c_pw+1)'(r_s2_pim);
    assign w_sum[2] = (c_pw+1)'(r_s2_a_re) - (c_pw+1)'(r_s2_pre);
    assign w_sum[3] = (c_pw+1)'(r_s2_a_im) - (c_pw+1)'(r_s2_pim);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rs
            round_sat #(
                .IN_W      (c_pw + 1),
                .OUT_W     (OUT_W),
                .BASE_DROP (base_drop(TW_FRAC, OUT_FRAC))
            ) u_round_sat (
                .din   (w_sum[gi]),
                .scale (r_s2_scale),
                .dout  (w_rs[gi]),
                .sat   (w_sat[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            out_valid  <= 1'b0;
            out1_re    <= '0;
            out1_im    <= '0;
            out2_re    <= '0;
            out2_im    <= '0;
            out_tag    <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (w_adv) begin
                r_s1_valid <= in_valid;
                r_s2_valid <= r_s1_valid;
                out_valid  <= r_s2_valid;
                out1_re    <= w_rs[0];
                out1_im    <= w_rs[1];
                out2_re    <= w_rs[2];
                out2_im    <= w_rs[3];
                out_tag    <= r_s2_tag;
            end
            // A fresh saturation takes priority over a simultaneous clear.
            if (w_adv && r_s2_valid && (|w_sat)) begin
                ovf_sticky <= 1'b1;
            end else if (clr_ovf) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_butterfly_unit_pipelined.sv
`default_nettype none
// ============================================================
// Module : tb_butterfly_unit_pipelined
// Self-checking bench: directed spec vectors plus randomized traffic vs model.
// Rev    : 1.0
// ============================================================
module tb_butterfly_unit_pipelined;
    import fft_pkg::*;

    localparam int DROP0 = 14 - 5;

    typedef struct { cplx_t a, b, w; bit inv, sc; logic [7:0] tag; } smp_t;
    typedef struct { longint o1r, o1i, o2r, o2i; logic [7:0] tag; } res_t;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, in_inverse, in_scale, out_valid, out_ready, ovf_sticky, clr_ovf;
    logic signed [15:0] in1_re, in1_im, in2_re, in2_im, tw_re, tw_im;
    logic [7:0] in_tag, out_tag, out_tag2;
    logic signed [23:0] out1_re, out1_im, out2_re, out2_im;
    logic signed [11:0] o1r2, o1i2, o2r2, o2i2;
    logic in_ready2, out_valid2, ovf2;

    int total = 0;
    int bad = 0;
    res_t got[$];
    res_t exp[$];

    always #5 clk = ~clk;

    butterfly_unit_pipelined dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1_re(in1_re), .in1_im(in1_im), .in2_re(in2_re), .in2_im(in2_im),
        .tw_re(tw_re), .tw_im(tw_im), .in_inverse(in_inverse), .in_scale(in_scale),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out1_re(out1_re), .out1_im(out1_im), .out2_re(out2_re), .out2_im(out2_im),
        .out_tag(out_tag), .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
    );

    butterfly_unit_pipelined #(.OUT_W(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in1_re(in1_re), .in1_im(in1_im), .in2_re(in2_re), .in2_im(in2_im),
        .tw_re(tw_re), .tw_im(tw_im), .in_inverse(in_inverse), .in_scale(in_scale),
        .in_tag(in_tag), .out_valid(out_valid2), .out_ready(out_ready),
        .out1_re(o1r2), .out1_im(o1i2), .out2_re(o2r2), .out2_im(o2i2),
        .out_tag(out_tag2), .ovf_sticky(ovf2), .clr_ovf(clr_ovf)
    );

    always @(negedge clk) begin
        res_t r;
        if (rst_n && out_valid && out_ready) begin
            r.o1r = out1_re; r.o1i = out1_im; r.o2r = out2_re; r.o2i = out2_im; r.tag = out_tag;
            got.push_back(r);
        end
    end

    function automatic longint rs(longint x, int d, int w);
        longint hi, r;
        hi = (longint'(1) <<< (w - 1)) - 1;
        r  = (d == 0) ? x : ((x + (longint'(1) <<< (d - 1))) >>> d);
        if (r > hi) r = hi;
        if (r < -hi - 1) r = -hi - 1;
        return r;
    endfunction

    function automatic res_t model(smp_t s, int w);
        longint br, bi, wr, wi, ar, ai, pr, pi;
        int d;
        res_t r;
        br = longint'($signed(s.b.re)); bi = longint'($signed(s.b.im));
        wr = longint'($signed(s.w.re)); wi = longint'($signed(s.w.im));
        if (s.inv) wi = -wi;
        ar = longint'($signed(s.a.re)) * TW_ONE;
        ai = longint'($signed(s.a.im)) * TW_ONE;
        pr = br * wr - bi * wi;
        pi = br * wi + bi * wr;
        d  = DROP0 + int'(s.sc);
        r.o1r = rs(ar + pr, d, w); r.o1i = rs(ai + pi, d, w);
        r.o2r = rs(ar - pr, d, w); r.o2i = rs(ai - pi, d, w);
        r.tag = s.tag;
        return r;
    endfunction

    function automatic smp_t mk(int ar, int ai, int br, int bi, int wr, int wi, bit inv, bit sc, logic [7:0] tag);
        smp_t s;
        s.a.re = 16'(ar); s.a.im = 16'(ai); s.b.re = 16'(br); s.b.im = 16'(bi);
        s.w.re = 16'(wr); s.w.im = 16'(wi); s.inv = inv; s.sc = sc; s.tag = tag;
        return s;
    endfunction

    function automatic smp_t rnd_smp(logic [7:0] tag);
        return mk(int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                  int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                  int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                  1'($urandom), 1'($urandom), tag);
    endfunction

    function automatic res_t mkr(longint a, longint b, longint c, longint d, logic [7:0] tag);
        res_t r;
        r.o1r = a; r.o1i = b; r.o2r = c; r.o2i = d; r.tag = tag;
        return r;
    endfunction

    task automatic send(input smp_t s, output bit ok);
        ok = 1'b0;
        in1_re = s.a.re; in1_im = s.a.im; in2_re = s.b.re; in2_im = s.b.im;
        tw_re = s.w.re; tw_im = s.w.im; in_inverse = s.inv; in_scale = s.sc; in_tag = s.tag;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout tag=%0h accepted=0 want=1", s.tag);
        end
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < 200 && got.size() < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_valid2();
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (out_valid2) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL sat_valid_timeout got=0 want=1"); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
        in1_re = '0; in1_im = '0; in2_re = '0; in2_im = '0; tw_re = '0; tw_im = '0;
        in_inverse = 1'b0; in_scale = 1'b0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        total++; if (ovf_sticky !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", ovf_sticky); end
        total++;
        if (out1_re !== 0 || out1_im !== 0 || out2_re !== 0 || out2_im !== 0 || out_tag !== 0) begin
            bad++; $display("FAIL rst_outputs got=(%0d,%0d,%0d,%0d,%0h) want=(0,0,0,0,0)",
                            out1_re, out1_im, out2_re, out2_im, out_tag);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        smp_t v[5];
        bit ok;
        got.delete(); exp.delete(); out_ready = 1'b1;
        v[0] = mk(100, 0, 50, 0, 16384, 0, 0, 0, 8'h11);
        v[1] = mk(0, 0, 10, 0, 0, -16384, 0, 0, 8'h22);
        v[2] = mk(0, 0, 10, 0, 0, -16384, 1, 0, 8'h33);
        v[3] = mk(3, 0, 0, 0, 16384, 0, 0, 1, 8'h44);
        v[4] = mk(0, 0, 1, 0, 256, 0, 0, 0, 8'h55);
        exp.push_back(mkr(4800, 0, 1600, 0, 8'h11));
        exp.push_back(mkr(0, -320, 0, 320, 8'h22));
        exp.push_back(mkr(0, 320, 0, -320, 8'h33));
        exp.push_back(mkr(48, 0, 48, 0, 8'h44));
        exp.push_back(mkr(1, 0, 0, 0, 8'h55));
        send(v[0], ok);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== (c == 2)) begin
                bad++; $display("FAIL latency cycle%0d got=%b want=%b", c, out_valid, (c == 2));
            end
        end
        @(posedge clk); #1;
        for (int i = 1; i < 5; i++) send(v[i], ok);
        drain(5);
        total++; if (got.size() != 5) begin bad++; $display("FAIL dir_count got=%0d want=5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            total++;
            if (got[i].o1r !== exp[i].o1r || got[i].o1i !== exp[i].o1i || got[i].o2r !== exp[i].o2r
                || got[i].o2i !== exp[i].o2i || got[i].tag !== exp[i].tag) begin
                bad++;
                $display("FAIL dir[%0d] got=(%0d,%0d,%0d,%0d,%0h) want=(%0d,%0d,%0d,%0d,%0h)", i,
                         got[i].o1r, got[i].o1i, got[i].o2r, got[i].o2i, got[i].tag,
                         exp[i].o1r, exp[i].o1i, exp[i].o2r, exp[i].o2i, exp[i].tag);
            end
        end
    endtask

    task automatic test_back_to_back();
        smp_t s[6];
        bit ok;
        got.delete(); exp.delete(); out_ready = 1'b1;
        for (int i = 0; i < 6; i++) s[i] = rnd_smp(8'hA0 + 8'(i));
        fork
            begin
                for (int i = 0; i < 6; i++) begin send(s[i], ok); exp.push_back(model(s[i], 24)); end
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready c%0d got=%b want=0", c, in_ready); end
                    total++;
                    if (out_valid !== 1'b1 || out1_re !== exp[got.size()].o1r || out1_im !== exp[got.size()].o1i
                        || out2_re !== exp[got.size()].o2r || out2_im !== exp[got.size()].o2i
                        || out_tag !== exp[got.size()].tag) begin
                        bad++;
                        $display("FAIL stall_hold c%0d got=(%0d,%0d,%0d,%0d,%0h) want=(%0d,%0d,%0d,%0d,%0h)", c,
                                 out1_re, out1_im, out2_re, out2_im, out_tag, exp[got.size()].o1r,
                                 exp[got.size()].o1i, exp[got.size()].o2r, exp[got.size()].o2i, exp[got.size()].tag);
                    end
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
                @(negedge clk);
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
            end
        join
        drain(6);
        total++; if (got.size() != 6) begin bad++; $display("FAIL b2b_count got=%0d want=6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            total++;
            if (got[i].o1r !== exp[i].o1r || got[i].o1i !== exp[i].o1i || got[i].o2r !== exp[i].o2r
                || got[i].o2i !== exp[i].o2i || got[i].tag !== exp[i].tag) begin
                bad++;
                $display("FAIL b2b[%0d] got=(%0d,%0d,%0d,%0d,%0h) want=(%0d,%0d,%0d,%0d,%0h)", i,
                         got[i].o1r, got[i].o1i, got[i].o2r, got[i].o2i, got[i].tag,
                         exp[i].o1r, exp[i].o1i, exp[i].o2r, exp[i].o2i, exp[i].tag);
            end
        end
    endtask

    task automatic test_random();
        smp_t s;
        bit ok;
        bit drv_done = 1'b0;
        got.delete(); exp.delete(); out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    s = rnd_smp(8'(i));
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send(s, ok);
                    exp.push_back(model(s, 24));
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain(60);
        total++; if (got.size() != 60) begin bad++; $display("FAIL rand_count got=%0d want=60", got.size()); end
        for (int i = 0; i < 60 && i < got.size(); i++) begin
            total++;
            if (got[i].o1r !== exp[i].o1r || got[i].o1i !== exp[i].o1i || got[i].o2r !== exp[i].o2r
                || got[i].o2i !== exp[i].o2i || got[i].tag !== exp[i].tag) begin
                bad++;
                $display("FAIL rand[%0d] got=(%0d,%0d,%0d,%0d,%0h) want=(%0d,%0d,%0d,%0d,%0h)", i,
                         got[i].o1r, got[i].o1i, got[i].o2r, got[i].o2i, got[i].tag,
                         exp[i].o1r, exp[i].o1i, exp[i].o2r, exp[i].o2i, exp[i].tag);
            end
        end
        total++; if (ovf_sticky !== 1'b0) begin bad++; $display("FAIL rand_ovf got=%b want=0", ovf_sticky); end
    endtask

    task automatic test_sat();
        smp_t s;
        bit ok;
        out_ready = 1'b1;
        s = mk(1000, 0, 1000, 0, 16384, 0, 0, 0, 8'h77);
        clr_ovf = 1'b1; @(posedge clk); #1; clr_ovf = 1'b0;
        @(negedge clk);
        total++; if (ovf2 !== 1'b0) begin bad++; $display("FAIL sat_preclear got=%b want=0", ovf2); end
        @(posedge clk); #1;
        send(s, ok);
        wait_valid2();
        total++;
        if (o1r2 !== 12'sd2047 || o1i2 !== 0 || o2r2 !== 0 || o2i2 !== 0 || out_tag2 !== 8'h77) begin
            bad++; $display("FAIL sat_values got=(%0d,%0d,%0d,%0d,%0h) want=(2047,0,0,0,77)",
                            o1r2, o1i2, o2r2, o2i2, out_tag2);
        end
        total++; if (ovf2 !== 1'b1) begin bad++; $display("FAIL sat_flag got=%b want=1", ovf2); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (ovf2 !== 1'b1) begin bad++; $display("FAIL sat_sticky got=%b want=1", ovf2); end
        @(posedge clk); #1 clr_ovf = 1'b1;
        @(posedge clk); #1 clr_ovf = 1'b0;
        @(negedge clk);
        total++; if (ovf2 !== 1'b0) begin bad++; $display("FAIL sat_clear got=%b want=0", ovf2); end
        @(posedge clk); #1 clr_ovf = 1'b1;
        send(s, ok);
        wait_valid2();
        total++; if (ovf2 !== 1'b1) begin bad++; $display("FAIL sat_set_wins got=%b want=1", ovf2); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (ovf2 !== 1'b0) begin bad++; $display("FAIL sat_clr_after got=%b want=0", ovf2); end
        @(posedge clk); #1 clr_ovf = 1'b0;
        drain(2);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int stale = 0;
        got.delete(); exp.delete(); out_ready = 1'b0;
        send(mk(1000, 0, 1000, 0, 16384, 0, 0, 0, 8'hE1), ok);
        send(rnd_smp(8'hE2), ok);
        send(rnd_smp(8'hE3), ok);
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || ovf2 !== 1'b1) begin
            bad++; $display("FAIL mid_full got=%b%b want=11", out_valid, ovf2);
        end
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", out_valid); end
        total++;
        if (out1_re !== 0 || out1_im !== 0 || out2_re !== 0 || out2_im !== 0 || out_tag !== 0) begin
            bad++; $display("FAIL mid_outputs got=(%0d,%0d,%0d,%0d,%0h) want=(0,0,0,0,0)",
                            out1_re, out1_im, out2_re, out2_im, out_tag);
        end
        total++; if (ovf_sticky !== 1'b0 || ovf2 !== 1'b0) begin
            bad++; $display("FAIL mid_ovf got=%b%b want=00", ovf_sticky, ovf2);
        end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", in_ready); end
        @(posedge clk); #1 out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        total++; if (stale != 0) begin bad++; $display("FAIL mid_stale got=%0d want=0", stale); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_sat();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
